timer0_counter: RTL and testbench

- 8-bit Timer/Counter0 for the rAVR core. It is the consumer of the prescaler's timer0 clock-select output.
- Drives `cs0[2:0]` to the prescaler and receives the selected count enable back on `clk_t0`.
- Provides a count register, a compare register, normal and CTC modes, and a toggling compare output.
- Raises overflow and compare-match interrupt flags on the core's 6-bit I/O register bus.

---
 rtl/timer_pkg.sv | 41 ++++
 rtl/timer0_counter.sv | 114 +++++++++++
 tb/tb_timer0_counter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the rAVR 8-bit timer/counter blocks:
// register offsets, clock-select encodings and control/flag bit positions.
package timer_pkg;

  // Register offsets relative to the block base address
  localparam logic [2:0] TCCR0_OFS  = 3'd0;
  localparam logic [2:0] TCNT0_OFS  = 3'd1;
  localparam logic [2:0] OCR0_OFS   = 3'd2;
  localparam logic [2:0] TIFR0_OFS  = 3'd3;
  localparam logic [2:0] TIMSK0_OFS = 3'd4;
  localparam logic [2:0] LAST_OFS   = TIMSK0_OFS;

  // Clock-select encodings understood by the prescaler
  typedef enum logic [2:0] {
    CS_STOP     = 3'd0,
    CS_CLK      = 3'd1,
    CS_DIV8     = 3'd2,
    CS_DIV64    = 3'd3,
    CS_DIV256   = 3'd4,
    CS_DIV1024  = 3'd5,
    CS_EXT_FALL = 3'd6,
    CS_EXT_RISE = 3'd7
  } cs_e;

  // TCCR0 bit positions
  localparam int CTC_BIT   = 3;
  localparam int COM_BIT   = 4;
  // TIFR0 bit positions
  localparam int TOV0_BIT  = 0;
  localparam int OCF0_BIT  = 1;
  // TIMSK0 bit positions
  localparam int TOIE0_BIT = 0;
  localparam int OCIE0_BIT = 1;

  // In CS_CLK mode the prescaler forwards the raw clock, so the enable is
  // implied every cycle and clk_t0 is not looked at.
  function automatic logic cs_tick(input logic [2:0] cs, input logic clk_t0);
    return (cs == CS_CLK) | ((cs >= CS_DIV8) & clk_t0);
  endfunction

endpackage

// File: rtl/timer0_counter.sv
// Timer/Counter0: 8-bit counter with compare, CTC mode, toggling compare
// output and overflow/compare interrupt flags on the 6-bit I/O bus.
module timer0_counter
  import timer_pkg::*;
#(
  parameter logic [5:0] base_addr = 6'h12
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [5:0] io_a,
  input  logic       io_we,
  input  logic       io_re,
  input  logic [7:0] io_di,
  output logic [7:0] io_do,
  output logic [2:0] cs0,
  input  logic       clk_t0,
  output logic       oc0,
  output logic       irq_ovf,
  output logic       irq_cmp,
  input  logic       irq_ovf_ack,
  input  logic       irq_cmp_ack
);

  logic [4:0] tccr;
  logic [7:0] tcnt;
  logic [7:0] ocr;
  logic [1:0] tifr;
  logic [1:0] timsk;

  logic [5:0] rel_a;
  logic       hit;
  logic [2:0] ofs;
  logic       wr_tccr, wr_tcnt, wr_ocr, wr_tifr, wr_timsk;
  logic       cnt_en, match, ovf;
  logic [7:0] tcnt_nxt;
  logic [1:0] tifr_nxt;
  logic [7:0] rd_data;

  // Address decode: offsets past the last register are not ours
  assign rel_a = io_a - base_addr;
  assign hit   = (rel_a <= {3'b000, LAST_OFS});
  assign ofs   = rel_a[2:0];

  assign wr_tccr  = io_we & hit & (ofs == TCCR0_OFS);
  assign wr_tcnt  = io_we & hit & (ofs == TCNT0_OFS);
  assign wr_ocr   = io_we & hit & (ofs == OCR0_OFS);
  assign wr_tifr  = io_we & hit & (ofs == TIFR0_OFS);
  assign wr_timsk = io_we & hit & (ofs == TIMSK0_OFS);

  assign cs0 = tccr[2:0];

  // A CPU write to TCNT0 suppresses the tick entirely, including match/overflow
  assign cnt_en = cs_tick(tccr[2:0], clk_t0) & ~wr_tcnt;
  assign match  = cnt_en & (tcnt == ocr);
  assign ovf    = cnt_en & (tcnt == 8'hFF);

  // Next count: CTC match and FF both return to 0; a CTC match at FF also
  // raises TOV0 through ovf, which is independent of the match path.
  always_comb begin
    tcnt_nxt = tcnt;
    if (wr_tcnt)                        tcnt_nxt = io_di;
    else if (match && tccr[CTC_BIT])    tcnt_nxt = 8'h00;
    else if (ovf)                       tcnt_nxt = 8'h00;
    else if (cnt_en)                    tcnt_nxt = tcnt + 8'h01;
  end

  // Flag update: write-1 or vector ack clears, a coincident set wins
  always_comb begin
    tifr_nxt = tifr;
    if (irq_ovf_ack || (wr_tifr && io_di[TOV0_BIT])) tifr_nxt[TOV0_BIT] = 1'b0;
    if (irq_cmp_ack || (wr_tifr && io_di[OCF0_BIT])) tifr_nxt[OCF0_BIT] = 1'b0;
    if (ovf)   tifr_nxt[TOV0_BIT] = 1'b1;
    if (match) tifr_nxt[OCF0_BIT] = 1'b1;
  end

  // Read mux; unmapped bits are zero
  always_comb begin
    rd_data = 8'h00;
    case (ofs)
      TCCR0_OFS:  rd_data = {3'b000, tccr};
      TCNT0_OFS:  rd_data = tcnt;
      OCR0_OFS:   rd_data = ocr;
      TIFR0_OFS:  rd_data = {6'b000000, tifr};
      TIMSK0_OFS: rd_data = {6'b000000, timsk};
      default:    rd_data = 8'h00;
    endcase
  end

  // Register file, counter, compare output and registered interrupt requests
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tccr    <= '0;
      tcnt    <= '0;
      ocr     <= '0;
      tifr    <= '0;
      timsk   <= '0;
      oc0     <= 1'b0;
      io_do   <= '0;
      irq_ovf <= 1'b0;
      irq_cmp <= 1'b0;
    end else begin
      if (wr_tccr)  tccr  <= io_di[4:0];
      if (wr_ocr)   ocr   <= io_di;
      if (wr_timsk) timsk <= io_di[1:0];
      tcnt <= tcnt_nxt;
      tifr <= tifr_nxt;
      if (match && tccr[COM_BIT]) oc0 <= ~oc0;
      if (io_re && hit) io_do <= rd_data;
      irq_ovf <= tifr[TOV0_BIT] & timsk[TOIE0_BIT];
      irq_cmp <= tifr[OCF0_BIT] & timsk[OCIE0_BIT];
    end
  end

endmodule

// File: tb/tb_timer0_counter.sv
// Directed bench for timer0_counter: a per-cycle vector table for the
// normal/CTC sequences plus hand sequences for stop, write-wins, ack races
// and asynchronous reset.
module tb_timer0_counter;

  localparam logic [5:0] BASE = 6'h12;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [5:0] io_a;
  logic       io_we, io_re;
  logic [7:0] io_di;
  logic [7:0] io_do;
  logic [2:0] cs0;
  logic       clk_t0;
  logic       oc0, irq_ovf, irq_cmp;
  logic       irq_ovf_ack, irq_cmp_ack;

  int nchk  = 0;
  int nfail = 0;

  timer0_counter #(.base_addr(BASE)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .io_a(io_a), .io_we(io_we), .io_re(io_re), .io_di(io_di), .io_do(io_do),
    .cs0(cs0), .clk_t0(clk_t0), .oc0(oc0),
    .irq_ovf(irq_ovf), .irq_cmp(irq_cmp),
    .irq_ovf_ack(irq_ovf_ack), .irq_cmp_ack(irq_cmp_ack)
  );

  always #5 sys_clk = ~sys_clk;

  // One cycle of stimulus: inputs set before, outputs checked after
  typedef struct {
    logic       we, re;
    logic [2:0] ofs;
    logic [7:0] di;
    logic       t0;
    logic       cdo;
    logic [7:0] edo;
    logic [2:0] ecs;
    logic       eoc, eiov, eicm;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic we, re, input logic [2:0] ofs,
                             input logic [7:0] di, input logic t0, cdo,
                             input logic [7:0] edo, input logic [2:0] ecs,
                             input logic eoc, eiov, eicm);
    vec_t r;
    r.we = we; r.re = re; r.ofs = ofs; r.di = di; r.t0 = t0; r.cdo = cdo;
    r.edo = edo; r.ecs = ecs; r.eoc = eoc; r.eiov = eiov; r.eicm = eicm;
    return r;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] ofs, input logic [7:0] d);
    io_a = BASE + {3'b000, ofs}; io_di = d; io_we = 1'b1;
    cyc();
    io_we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] ofs, output logic [7:0] d);
    io_a = BASE + {3'b000, ofs}; io_re = 1'b1;
    cyc();
    io_re = 1'b0;
    d = io_do;
  endtask

  logic [7:0] r;

  initial begin
    sys_rst = 1'b1; io_a = '0; io_we = 0; io_re = 0; io_di = '0;
    clk_t0 = 0; irq_ovf_ack = 0; irq_cmp_ack = 0;

    // reset reads; timer run in CS_CLK through FD..00 overflow
    for (int k = 0; k < 5; k++) tbl.push_back(v(0,1,3'(k),8'h00,0, 1,8'h00, 0,0,0,0));
    tbl.push_back(v(1,0,3'd4,8'h01,0, 0,8'h00, 0,0,0,0)); // TIMSK0 = TOIE0
    tbl.push_back(v(1,0,3'd1,8'hFD,0, 0,8'h00, 0,0,0,0)); // TCNT0 = FD
    tbl.push_back(v(1,0,3'd0,8'h01,0, 0,8'h00, 1,0,0,0)); // CS = 1
    tbl.push_back(v(0,1,3'd1,8'h00,0, 1,8'hFD, 1,0,0,0));
    tbl.push_back(v(0,1,3'd1,8'h00,0, 1,8'hFE, 1,0,0,0));
    tbl.push_back(v(0,1,3'd1,8'h00,0, 1,8'hFF, 1,0,0,0)); // FF->00 sets TOV0
    tbl.push_back(v(0,1,3'd1,8'h00,0, 1,8'h00, 1,0,1,0)); // irq 1 cycle later; 00==OCR0 sets OCF0
    tbl.push_back(v(1,0,3'd0,8'h00,0, 0,8'h00, 0,0,1,0)); // stop (last tick 01->02)
    tbl.push_back(v(0,1,3'd3,8'h00,0, 1,8'h03, 0,0,1,0));
    tbl.push_back(v(1,0,3'd3,8'h01,0, 0,8'h00, 0,0,1,0)); // W1C TOV0
    tbl.push_back(v(0,1,3'd3,8'h00,0, 1,8'h02, 0,0,0,0));
    tbl.push_back(v(1,0,3'd3,8'h02,0, 0,8'h00, 0,0,0,0)); // W1C OCF0
    tbl.push_back(v(0,1,3'd1,8'h00,0, 1,8'h02, 0,0,0,0));
    // CTC with OCR0=3, COM toggle, clk_t0 pulses
    tbl.push_back(v(1,0,3'd2,8'h03,0, 0,8'h00, 0,0,0,0));
    tbl.push_back(v(1,0,3'd1,8'h00,0, 0,8'h00, 0,0,0,0));
    tbl.push_back(v(1,0,3'd4,8'h02,0, 0,8'h00, 0,0,0,0));
    tbl.push_back(v(1,0,3'd0,8'h1A,0, 0,8'h00, 2,0,0,0));
    tbl.push_back(v(0,1,3'd1,8'h00,1, 1,8'h00, 2,0,0,0));
    tbl.push_back(v(0,1,3'd1,8'h00,0, 1,8'h01, 2,0,0,0)); // no pulse, holds
    tbl.push_back(v(0,1,3'd1,8'h00,1, 1,8'h01, 2,0,0,0));
    tbl.push_back(v(0,1,3'd1,8'h00,1, 1,8'h02, 2,0,0,0));
    tbl.push_back(v(0,1,3'd1,8'h00,1, 1,8'h03, 2,1,0,0)); // match at 3
    tbl.push_back(v(0,1,3'd3,8'h00,0, 1,8'h02, 2,1,0,1));
    tbl.push_back(v(0,1,3'd1,8'h00,1, 1,8'h00, 2,1,0,1));
    tbl.push_back(v(0,0,3'd0,8'h00,1, 0,8'h00, 2,1,0,1));
    tbl.push_back(v(0,0,3'd0,8'h00,1, 0,8'h00, 2,1,0,1));
    tbl.push_back(v(0,1,3'd1,8'h00,1, 1,8'h03, 2,0,0,1)); // second match toggles back
    tbl.push_back(v(0,1,3'd1,8'h00,0, 1,8'h00, 2,0,0,1));
    tbl.push_back(v(1,0,3'd3,8'h02,0, 0,8'h00, 2,0,0,1));
    tbl.push_back(v(0,1,3'd3,8'h00,0, 1,8'h00, 2,0,0,0)); // TOV0 never set
    tbl.push_back(v(1,0,3'd0,8'h00,0, 0,8'h00, 0,0,0,0));

    repeat (2) cyc();
    sys_rst = 1'b0;
    cyc();

    foreach (tbl[i]) begin
      io_a = BASE + {3'b000, tbl[i].ofs}; io_di = tbl[i].di;
      io_we = tbl[i].we; io_re = tbl[i].re; clk_t0 = tbl[i].t0;
      cyc();
      io_we = 0; io_re = 0; clk_t0 = 0;
      if (tbl[i].cdo) chk($sformatf("row%0d io_do", i), io_do, tbl[i].edo);
      chk($sformatf("row%0d cs0", i), {5'b0, cs0}, {5'b0, tbl[i].ecs});
      chk($sformatf("row%0d oc0", i), {7'b0, oc0}, {7'b0, tbl[i].eoc});
      chk($sformatf("row%0d irq_ovf", i), {7'b0, irq_ovf}, {7'b0, tbl[i].eiov});
      chk($sformatf("row%0d irq_cmp", i), {7'b0, irq_cmp}, {7'b0, tbl[i].eicm});
    end

    // stopped: clk_t0 ignored with CS=0; CS=2 without clk_t0 holds
    wr(3'd1, 8'h55);
    clk_t0 = 1'b1;
    repeat (20) cyc();
    clk_t0 = 1'b0;
    rd(3'd1, r); chk("cs0_stop_hold", r, 8'h55);
    wr(3'd0, 8'h02);
    repeat (10) cyc();
    rd(3'd1, r); chk("cs2_no_t0_hold", r, 8'h55);
    chk("cs0_div8", {5'b0, cs0}, 8'h02);

    // TCNT0 write coincident with a matching tick: write wins
    wr(3'd2, 8'h10);
    wr(3'd1, 8'h10);
    wr(3'd0, 8'h12);
    io_a = BASE + 6'd1; io_di = 8'h40; io_we = 1'b1; clk_t0 = 1'b1;
    cyc();
    io_we = 1'b0; clk_t0 = 1'b0;
    rd(3'd1, r); chk("wr_wins_tcnt", r, 8'h40);
    rd(3'd3, r); chk("wr_wins_no_ocf", r, 8'h00);
    chk("wr_wins_no_toggle", {7'b0, oc0}, 8'h00);

    // overflow set coincident with ack: set wins; lone ack clears
    wr(3'd1, 8'hFF);
    clk_t0 = 1'b1; irq_ovf_ack = 1'b1;
    cyc();
    clk_t0 = 1'b0; irq_ovf_ack = 1'b0;
    rd(3'd3, r); chk("ovf_set_beats_ack", r, 8'h01);
    irq_ovf_ack = 1'b1;
    cyc();
    irq_ovf_ack = 1'b0;
    rd(3'd3, r); chk("ovf_ack_clears", r, 8'h00);

    // compare set coincident with ack: set wins, oc0 toggles
    wr(3'd1, 8'h10);
    clk_t0 = 1'b1; irq_cmp_ack = 1'b1;
    cyc();
    clk_t0 = 1'b0; irq_cmp_ack = 1'b0;
    rd(3'd3, r); chk("cmp_set_beats_ack", r, 8'h02);
    chk("cmp_toggle_oc0", {7'b0, oc0}, 8'h01);
    irq_cmp_ack = 1'b1;
    cyc();
    irq_cmp_ack = 1'b0;
    rd(3'd3, r); chk("cmp_ack_clears", r, 8'h00);

    // asynchronous reset while counting
    wr(3'd0, 8'h01);
    repeat (3) cyc();
    rd(3'd1, r);
    chk("pre_rst_counting", {7'b0, (r > 8'h11)}, 8'h01);
    #2 sys_rst = 1'b1;
    #1;
    chk("arst_io_do", io_do, 8'h00);
    chk("arst_cs0", {5'b0, cs0}, 8'h00);
    chk("arst_oc0", {7'b0, oc0}, 8'h00);
    chk("arst_irqs", {6'b0, irq_ovf, irq_cmp}, 8'h00);
    #1 sys_rst = 1'b0;
    cyc();
    rd(3'd1, r); chk("post_rst_tcnt", r, 8'h00);
    rd(3'd0, r); chk("post_rst_tccr", r, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
